// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// Holds the default address/data widths, the program length, the reset
// fetch address and the fetch FSM state encoding.
package fetch_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 16;
    localparam int PROG_LEN = 16;
    localparam int RESET_PC = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_pc_counter.sv
// Program counter for the fetch stage.
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset (pc -> RESET_PC)
//   i_load           load pc with i_load_addr (has priority over i_inc)
//   i_load_addr      load value, taken as-is even beyond the program end
//   i_inc            advance pc with wrap; any pc at/above PROG_LEN-1 wraps to 0
//   o_pc             current program counter
module pc_counter
    import fetch_pkg::*;
#(
    parameter int P_ADDR_W   = ADDR_W,
    parameter int P_PROG_LEN = PROG_LEN,
    parameter int P_RESET_PC = RESET_PC
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_load,
    input  logic [P_ADDR_W-1:0] i_load_addr,
    input  logic                i_inc,
    output logic [P_ADDR_W-1:0] o_pc
);

    localparam logic [P_ADDR_W-1:0] LAST_PC   = P_ADDR_W'(P_PROG_LEN - 1);
    localparam logic [P_ADDR_W-1:0] RESET_VAL = P_ADDR_W'(P_RESET_PC);
    localparam logic [P_ADDR_W-1:0] PC_ZERO   = {P_ADDR_W{1'b0}};
    localparam logic [P_ADDR_W-1:0] PC_ONE    = {{(P_ADDR_W-1){1'b0}}, 1'b1};

    logic [P_ADDR_W-1:0] r_pc;
    logic [P_ADDR_W-1:0] w_pc_next;

    // Increment with wrap; ">=" also folds out-of-program jump targets back to 0.
    always_comb begin
        w_pc_next = PC_ZERO;
        if (r_pc >= LAST_PC) begin
            w_pc_next = PC_ZERO;
        end else begin
            w_pc_next = r_pc + PC_ONE;
        end
    end

    // PC register: load beats increment, otherwise hold.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc <= RESET_VAL;
        end else if (i_load) begin
            r_pc <= i_load_addr;
        end else if (i_inc) begin
            r_pc <= w_pc_next;
        end else begin
            r_pc <= r_pc;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage in front of a combinational, oe-gated program ROM.
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_en               run enable; low suppresses new fetches
//   o_rom_oe/o_rom_addr ROM enable and address (address is always pc)
//   i_rom_data         ROM word for the current address
//   o_instr/o_instr_valid/i_instr_ready  instruction handshake to the decoder
//   i_jmp_en/i_jmp_addr  redirect pc and flush the instruction register
//   i_halt             enter HALT (left only by jump or reset)
//   o_pc, o_halted     current fetch address, HALT indication
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int P_ADDR_W   = ADDR_W,
    parameter int P_DATA_W   = DATA_W,
    parameter int P_PROG_LEN = PROG_LEN,
    parameter int P_RESET_PC = RESET_PC
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    output logic                o_rom_oe,
    output logic [P_ADDR_W-1:0] o_rom_addr,
    input  logic [P_DATA_W-1:0] i_rom_data,
    output logic [P_DATA_W-1:0] o_instr,
    output logic                o_instr_valid,
    input  logic                i_instr_ready,
    input  logic                i_jmp_en,
    input  logic [P_ADDR_W-1:0] i_jmp_addr,
    input  logic                i_halt,
    output logic [P_ADDR_W-1:0] o_pc,
    output logic                o_halted
);

    fetch_state_t          r_state;
    logic [P_DATA_W-1:0]   r_instr;
    logic                  r_instr_valid;
    logic                  r_halted;

    fetch_state_t          w_state_next;
    logic                  w_rom_oe;
    logic                  w_ir_load;
    logic                  w_pc_load;
    logic                  w_pc_inc;
    logic                  w_valid_next;
    logic                  w_halted_next;
    logic [P_ADDR_W-1:0]   w_pc;

    pc_counter #(
        .P_ADDR_W   (P_ADDR_W),
        .P_PROG_LEN (P_PROG_LEN),
        .P_RESET_PC (P_RESET_PC)
    ) u_pc_counter (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (w_pc_load),
        .i_load_addr (i_jmp_addr),
        .i_inc       (w_pc_inc),
        .o_pc        (w_pc)
    );

    // ROM is enabled whenever this cycle could load a word: in FETCH, or in
    // HOLD when the current word is being consumed and running is enabled.
    always_comb begin
        w_rom_oe = 1'b0;
        if (r_state == ST_FETCH) begin
            w_rom_oe = 1'b1;
        end else if ((r_state == ST_HOLD) && i_instr_ready && i_en) begin
            w_rom_oe = 1'b1;
        end else begin
            w_rom_oe = 1'b0;
        end
    end

    // Next-state and control: jump beats halt beats normal sequencing.
    always_comb begin
        w_state_next  = r_state;
        w_ir_load     = 1'b0;
        w_pc_load     = 1'b0;
        w_pc_inc      = 1'b0;
        w_valid_next  = r_instr_valid;
        w_halted_next = r_halted;
        if (i_jmp_en) begin
            // Flush: the held word is dropped even if the decoder is ready.
            w_state_next  = ST_FETCH;
            w_pc_load     = 1'b1;
            w_valid_next  = 1'b0;
            w_halted_next = 1'b0;
        end else if (i_halt && (r_state != ST_HALT)) begin
            // Any word fetched this cycle is not loaded; pc stays put.
            w_state_next  = ST_HALT;
            w_valid_next  = 1'b0;
            w_halted_next = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_en) begin
                        w_state_next = ST_FETCH;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    w_ir_load    = 1'b1;
                    w_pc_inc     = 1'b1;
                    w_valid_next = 1'b1;
                    w_state_next = ST_HOLD;
                end
                ST_HOLD: begin
                    if (i_instr_ready && i_en) begin
                        w_ir_load    = 1'b1;
                        w_pc_inc     = 1'b1;
                        w_valid_next = 1'b1;
                        w_state_next = ST_HOLD;
                    end else if (i_instr_ready) begin
                        w_valid_next = 1'b0;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_HOLD;
                    end
                end
                ST_HALT: begin
                    w_state_next = ST_HALT;
                end
                default: begin
                    w_state_next  = ST_IDLE;
                    w_valid_next  = 1'b0;
                    w_halted_next = 1'b0;
                end
            endcase
        end
    end

    // State, instruction register and status flags.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_instr       <= {P_DATA_W{1'b0}};
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_instr       <= w_ir_load ? i_rom_data : r_instr;
            r_instr_valid <= w_valid_next;
            r_halted      <= w_halted_next;
        end
    end

    assign o_rom_oe      = w_rom_oe;
    assign o_rom_addr    = w_pc;
    assign o_pc          = w_pc;
    assign o_instr       = r_instr;
    assign o_instr_valid = r_instr_valid;
    assign o_halted      = r_halted;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic. A
// reference stream of expected accepted words (sequential ROM addresses from
// the last reset/jump target, with wrap) is queued by the stimulus side and
// consumed by a monitor at every completed handshake.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        en;
    logic        rom_oe;
    logic [4:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        jmp_en;
    logic [4:0]  jmp_addr;
    logic        halt;
    logic [4:0]  pc;
    logic        halted;

    logic [15:0] rom_mem [16];
    logic [15:0] exp_q [$];
    int          errors;
    int          checks;
    int          n_accept;

    instr_fetch dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_en          (en),
        .o_rom_oe      (rom_oe),
        .o_rom_addr    (rom_addr),
        .i_rom_data    (rom_data),
        .o_instr       (instr),
        .o_instr_valid (instr_valid),
        .i_instr_ready (instr_ready),
        .i_jmp_en      (jmp_en),
        .i_jmp_addr    (jmp_addr),
        .i_halt        (halt),
        .o_pc          (pc),
        .o_halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [4:0] a);
        if (a < 5'd16) return rom_mem[a[3:0]];
        return 16'h0000;
    endfunction

    // ROM model: combinational, outputs 0 when not enabled.
    always_comb begin
        rom_data = rom_oe ? rom_word(rom_addr) : 16'h0000;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected accepted stream restarting at 'start'.
    task automatic restart(input logic [4:0] start);
        logic [4:0] a;
        exp_q.delete();
        a = start;
        for (int i = 0; i < 512; i++) begin
            exp_q.push_back(rom_word(a));
            a = (a >= 5'd15) ? 5'd0 : a + 5'd1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a handshake completes at the next rising edge unless flushed.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (instr_valid && instr_ready && !jmp_en && !rst) begin
                n_accept++;
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_instr", {16'h0, instr}, {16'h0, e});
                end
            end
        end
    end

    initial begin
        int r;
        errors = 0; checks = 0; n_accept = 0;
        for (int i = 0; i < 16; i++) rom_mem[i] = 16'h2000 + 16'(i * 16'h0111);
        rom_mem[0] = 16'h1001; rom_mem[1] = 16'h1002;
        rom_mem[2] = 16'h1003; rom_mem[3] = 16'h1004;
        rom_mem[15] = 16'hABCD;

        rst = 1'b1; en = 1'b0; instr_ready = 1'b0;
        jmp_en = 1'b0; jmp_addr = 5'd0; halt = 1'b0;
        #12;
        chk("rst_instr", {16'h0, instr}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_pc", {27'h0, pc}, 32'h0);
        chk("rst_oe", {31'h0, rom_oe}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);

        // Sequential fetch at full throughput.
        tick();
        rst = 1'b0; restart(5'd0); en = 1'b1; instr_ready = 1'b1;
        tick();
        chk("fetch_oe", {31'h0, rom_oe}, 32'h1);
        chk("fetch_latency_valid", {31'h0, instr_valid}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("seq_instr", {16'h0, instr}, {16'h0, rom_mem[k]});
            chk("seq_pc", {27'h0, pc}, 32'(k + 1));
        end

        // Decoder stall: word and pc held, ROM idle.
        instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_instr", {16'h0, instr}, 32'h1004);
            chk("stall_valid", {31'h0, instr_valid}, 32'h1);
            chk("stall_pc", {27'h0, pc}, 32'd4);
            chk("stall_oe", {31'h0, rom_oe}, 32'h0);
        end
        instr_ready = 1'b1;
        tick();
        chk("resume_instr", {16'h0, instr}, {16'h0, rom_mem[4]});
        chk("resume_pc", {27'h0, pc}, 32'd5);

        // Jump from HOLD at pc=5 while the decoder is ready: word flushed.
        jmp_en = 1'b1; jmp_addr = 5'd12; restart(5'd12);
        tick();
        jmp_en = 1'b0;
        chk("jmp_valid", {31'h0, instr_valid}, 32'h0);
        chk("jmp_pc", {27'h0, pc}, 32'd12);
        chk("jmp_oe", {31'h0, rom_oe}, 32'h1);
        tick();
        chk("jmp_instr", {16'h0, instr}, {16'h0, rom_mem[12]});
        chk("jmp_pc_next", {27'h0, pc}, 32'd13);
        tick(); tick(); tick();
        chk("wrap_cell15", {16'h0, instr}, 32'hABCD);
        chk("wrap_pc", {27'h0, pc}, 32'd0);
        tick();
        chk("wrap_cell0", {16'h0, instr}, 32'h1001);
        for (int k = 0; k < 6; k++) tick();
        chk("pre_halt_pc", {27'h0, pc}, 32'd7);

        // Halt at pc=7, then leave via jump to 0.
        halt = 1'b1;
        tick();
        halt = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("halt_halted", {31'h0, halted}, 32'h1);
            chk("halt_valid", {31'h0, instr_valid}, 32'h0);
            chk("halt_oe", {31'h0, rom_oe}, 32'h0);
            chk("halt_pc", {27'h0, pc}, 32'd7);
            tick();
        end
        jmp_en = 1'b1; jmp_addr = 5'd0; restart(5'd0);
        tick();
        jmp_en = 1'b0;
        chk("unhalt_halted", {31'h0, halted}, 32'h0);
        tick();
        chk("unhalt_instr", {16'h0, instr}, 32'h1001);
        tick();

        // Asynchronous reset between edges while holding.
        instr_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_instr", {16'h0, instr}, 32'h0);
        chk("arst_valid", {31'h0, instr_valid}, 32'h0);
        chk("arst_pc", {27'h0, pc}, 32'h0);
        chk("arst_oe", {31'h0, rom_oe}, 32'h0);
        tick();
        rst = 1'b0; restart(5'd0); instr_ready = 1'b1;
        tick();
        tick();
        chk("arst_first_instr", {16'h0, instr}, 32'h1001);

        // Randomized traffic against the reference stream.
        n_accept = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (rst) begin
                rst = 1'b0;
                restart(5'd0);
            end else begin
                r = int'($urandom_range(0, 999));
                jmp_en = 1'b0;
                halt = 1'b0;
                if (r < 4) begin
                    rst = 1'b1;
                    restart(5'd0);
                end else if (r < 50) begin
                    jmp_addr = 5'($urandom_range(0, 31));
                    jmp_en = 1'b1;
                    restart(jmp_addr);
                end else if (r < 75) begin
                    halt = 1'b1;
                end
                en = ($urandom_range(0, 9) != 0);
                instr_ready = ($urandom_range(0, 9) < 7);
            end
        end
        tick();
        chk("random_accepts", {31'h0, (n_accept > 200)}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the 16-cell program ROM (combinational, `oe`-gated, 5-bit address, 16-bit data).
- Owns the program counter and drives ROM `oe`/`addr`.
- Registers the returned word into an instruction register and hands it to the decoder over a valid/ready handshake.
- Supports jumps, halt and wrap-around at program end.

Parameters:
ADDR_W, 5, ROM address width
DATA_W, 16, instruction width
PROG_LEN, 16, number of valid program cells; PC wraps after PROG_LEN-1
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
en  in  1  run enable; low suppresses new fetches
rom_oe  out  1  ROM output enable
rom_addr  out  ADDR_W  ROM address (= pc)
rom_data  in  DATA_W  ROM cell data, combinational from rom_addr/rom_oe
instr  out  DATA_W  instruction register
instr_valid  out  1  instr holds an unconsumed instruction
instr_ready  in  1  decoder accepts instr this cycle
jmp_en  in  1  load PC with jmp_addr, flush instr
jmp_addr  in  ADDR_W  jump target
halt  in  1  stop fetching
pc  out  ADDR_W  current fetch address
halted  out  1  block is in HALT state

Behaviour:
- Reset (async, rst=1): state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, halted=0, rom_oe=0.
- States: IDLE, FETCH, HOLD, HALT (encoding in package).
- rom_addr = pc always.
- rom_oe = (state==FETCH) | (state==HOLD & instr_ready & en). It is 0 in IDLE/HALT, so the ROM outputs 0.
- pc_next = (pc >= PROG_LEN-1) ? 0 : pc+1. Wrap applies to any pc at or above PROG_LEN-1.
- Priority per cycle: rst > jmp_en > halt > normal FSM.
- IDLE:
  - en=1 -> FETCH.
  - Otherwise stay.
- FETCH (rom_oe=1):
  - At edge: instr<=rom_data, instr_valid<=1, pc<=pc_next, -> HOLD.
  - Latency: one cycle from entering FETCH to instr_valid.
- HOLD (instr_valid=1):
  - instr and instr_valid stable while instr_ready=0.
  - instr_ready=1 & en=1: back-to-back fetch in the same cycle. rom_oe=1; at edge instr<=rom_data, pc<=pc_next, valid stays 1. Throughput is 1 instruction/cycle.
  - instr_ready=1 & en=0: valid<=0 -> IDLE. pc unchanged.
- jmp_en=1 (any state except reset):
  - At edge: pc<=jmp_addr, instr_valid<=0 (flush), halted<=0, -> FETCH.
  - The current instr is discarded even if instr_ready=1 in the same cycle.
  - The decoder must not count it as accepted.
- halt=1 (no jmp_en):
  - At edge: -> HALT, instr_valid<=0, halted<=1, pc frozen.
  - A handshake completing in the same cycle counts as accepted. The word that would have been fetched is not loaded.
- HALT: rom_oe=0. Exit only via jmp_en or rst. en and halt are ignored while in HALT.
- jmp_addr >= PROG_LEN is loaded as-is. ROM returns 0 for cells 16..31; the next increment wraps to 0.
- Reset mid-operation: all state cleared immediately, asynchronously. The first fetch after reset release occurs at RESET_PC.

Decomposition:
- Shared package `fetch_pkg`: state enum (IDLE/FETCH/HOLD/HALT), ADDR_W/DATA_W defaults, PROG_LEN.
- One natural sub-module: `pc_counter`. It holds the async-reset PC register with load (jmp), increment-with-wrap, and hold controls. FSM and IR stay in `instr_fetch`.

Test Plan:
- ROM cells 0..3 = 16'h1001..16'h1004; rst pulse, en=1, instr_ready=1 -> instr 1001,1002,1003,1004 on consecutive cycles after the first FETCH cycle; pc 1,2,3,4.
- instr_ready=0 for 3 cycles after first instr -> instr=16'h1001, valid=1 held, pc=1, rom_oe=0; ready=1 -> next cycle instr=16'h1002.
- Run through to pc=15 (CELL15=16'hABCD) -> after fetching cell 15, pc=0, next instr=CELL00.
- In HOLD at pc=5, jmp_en=1, jmp_addr=12 with instr_ready=1 -> next cycle valid=0, pc=12, state FETCH; following cycle instr=CELL12, pc=13.
- halt=1 at pc=7 -> halted=1, valid=0, rom_oe=0, pc stays 7 for 10 cycles with en=1; jmp_en, jmp_addr=0 -> halted=0, instr=CELL00 two cycles later.
- rst asserted asynchronously mid-HOLD (between edges) -> instr=0, valid=0, pc=0, rom_oe=0 immediately; after release with en=1 the first instr = CELL00.
